// File: rtl/pattern_detector_param.sv
// Serial pattern detector with a runtime-loadable W-bit pattern,
// overlapping/non-overlapping detection and a saturating match counter.
// The match pulse is Mealy: it is asserted in the same cycle the final
// pattern bit is presented on `in`.
module pattern_detector_param #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PAT_RST = 4'b1001,
    parameter int             CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [W-1:0]     pat_in,
    input  logic             count_clr,
    output logic             out,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int               FILL_W   = $clog2(W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [W-1:0]      pat_reg,   pat_next;
    logic [W-2:0]      hist_reg,  hist_next;
    logic [FILL_W-1:0] fill_reg,  fill_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              sat_reg,   sat_next;

    // Candidate window: the last W-1 accepted bits followed by the current bit.
    logic [W-1:0] window;
    logic         match;

    // Combinational match detection; a match needs a full history since the
    // last pattern load / reset / non-overlapping match.
    always_comb begin
        window = {hist_reg, in};
        match  = rst & valid & ~pat_load & (fill_reg == FILL_MAX) & (window == pat_reg);
    end

    // Next-state logic for pattern, history, fill level, counter and sticky flag.
    always_comb begin
        pat_next   = pat_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        count_next = count_reg;
        sat_next   = sat_reg;

        if (pat_load) begin
            // A new pattern invalidates any partial history; the bit on `in`
            // is dropped this cycle.
            pat_next  = pat_in;
            fill_next = '0;
        end else if (valid) begin
            hist_next = window[W-2:0];
            if (match && !overlap) begin
                fill_next = '0;
            end else if (fill_reg != FILL_MAX) begin
                fill_next = fill_reg + 1'b1;
            end
        end

        // Clear has priority over a coincident match; the match still
        // advances history/fill above.
        if (count_clr) begin
            count_next = '0;
            sat_next   = 1'b0;
        end else if (match) begin
            if (count_reg == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg   <= PAT_RST;
            hist_reg  <= '0;
            fill_reg  <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            pat_reg   <= pat_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            count_reg <= count_next;
            sat_reg   <= sat_next;
        end
    end

    assign out   = match;
    assign count = count_reg;
    assign sat   = sat_reg;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench for pattern_detector_param: two instances (default 16-bit counter
// with pattern 1001, and a 4-bit counter with an all-ones pattern) share
// stimulus and are compared every cycle against a queue-based model.
module tb_pattern_detector_param;

    typedef bit bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        valid = 1'b0;
    logic        overlap = 1'b0;
    logic        pat_load = 1'b0;
    logic [3:0]  pat_in = 4'b0000;
    logic        count_clr = 1'b0;

    logic        out0, out1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic        sat0, sat1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: accepted bits since the last history flush.
    bq_t        q0, q1;
    logic [3:0] m_pat[2];
    int         m_cnt[2];
    bit         m_sat[2];
    int         m_max[2];

    bit         obs_out0, obs_out1;
    logic [31:0] pulses;

    pattern_detector_param #(.W(4), .PAT_RST(4'b1001), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in(din), .valid(valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
        .out(out0), .count(cnt0), .sat(sat0)
    );

    pattern_detector_param #(.W(4), .PAT_RST(4'b1111), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in(din), .valid(valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
        .out(out1), .count(cnt1), .sat(sat1)
    );

    always #5 clk = ~clk;

    // A match needs exactly three remembered bits plus the current one equal to the pattern.
    function automatic bit model_match(input bq_t q, input logic [3:0] p, input bit b);
        int v;
        v = 0;
        if (q.size() != 3) return 1'b0;
        foreach (q[k]) v = (v << 1) | int'(q[k]);
        v = (v << 1) | int'(b);
        return v[3:0] == p;
    endfunction

    function automatic bq_t next_q(input bq_t q, input bit pl, input bit v,
                                   input bit b, input bit hit, input bit ov);
        bq_t r;
        r = q;
        if (pl) r.delete();
        else if (v) begin
            if (hit && !ov) r.delete();
            else begin
                r.push_back(b);
                if (r.size() > 3) void'(r.pop_front());
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_pat[0] = 4'b1001;
        m_pat[1] = 4'b1111;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_sat[0] = 1'b0; m_sat[1] = 1'b0;
        m_max[0] = 65535; m_max[1] = 15;
    endtask

    // One clock cycle: entered just after a rising edge.
    task automatic cycle(input bit b, input bit v, input bit ov, input bit pl,
                         input logic [3:0] pi, input bit clr);
        bit e0, e1;
        din = b; valid = v; overlap = ov; pat_load = pl; pat_in = pi; count_clr = clr;
        #4;
        e0 = v && !pl && model_match(q0, m_pat[0], b);
        e1 = v && !pl && model_match(q1, m_pat[1], b);
        obs_out0 = out0;
        obs_out1 = out1;
        n_vec++;
        if (out0 !== e0) begin
            n_err++;
            $display("FAIL out0 t=%0t got %b want %b", $time, out0, e0);
        end
        n_vec++;
        if (out1 !== e1) begin
            n_err++;
            $display("FAIL out1 t=%0t got %b want %b", $time, out1, e1);
        end
        @(posedge clk);
        q0 = next_q(q0, pl, v, b, e0, ov);
        q1 = next_q(q1, pl, v, b, e1, ov);
        if (pl) begin
            m_pat[0] = pi;
            m_pat[1] = pi;
        end
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                m_cnt[i] = 0;
                m_sat[i] = 1'b0;
            end else if ((i == 0) ? e0 : e1) begin
                if (m_cnt[i] == m_max[i]) m_sat[i] = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end
        end
        #1;
        n_vec++;
        if (int'(cnt0) != m_cnt[0] || sat0 !== m_sat[0]) begin
            n_err++;
            $display("FAIL cnt0/sat0 t=%0t got %0d/%b want %0d/%b", $time, cnt0, sat0, m_cnt[0], m_sat[0]);
        end
        n_vec++;
        if (int'(cnt1) != m_cnt[1] || sat1 !== m_sat[1]) begin
            n_err++;
            $display("FAIL cnt1/sat1 t=%0t got %0d/%b want %0d/%b", $time, cnt1, sat1, m_cnt[1], m_sat[1]);
        end
    endtask

    // Serial stream, MSB first; records dut0 pulses in the same bit order.
    task automatic stream(input logic [31:0] bits, input int n, input bit ov);
        pulses = '0;
        for (int k = n - 1; k >= 0; k--) begin
            cycle(bits[k], 1'b1, ov, 1'b0, 4'b0000, 1'b0);
            pulses[k] = obs_out0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        din = 1'b0; valid = 1'b0; pat_load = 1'b0; count_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        valid = 1'b1;
        din = 1'b1;
        #1;
        check_val("reset_out0", int'(out0), 0);
        check_val("reset_out1", int'(out1), 0);
        check_val("reset_cnt0", int'(cnt0), 0);
        check_val("reset_sat1", int'(sat1), 0);
        @(posedge clk);
        #1;
        check_val("reset_hold_out0", int'(out0), 0);
        rst = 1'b1;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_overlap();
        do_reset();
        stream(32'b1001001, 7, 1'b1);
        check_val("ovl_pulses", int'(pulses), 32'b0001001);
        check_val("ovl_count", int'(cnt0), 2);
        $display("test_overlap done count=%0d", cnt0);
    endtask

    task automatic test_nonoverlap();
        do_reset();
        stream(32'b1001001, 7, 1'b0);
        check_val("novl_pulses", int'(pulses), 32'b0001000);
        check_val("novl_count", int'(cnt0), 1);
        do_reset();
        stream(32'b10011001, 8, 1'b0);
        check_val("novl_count2", int'(cnt0), 2);
        $display("test_nonoverlap done count=%0d", cnt0);
    endtask

    task automatic test_pat_load();
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);
        check_val("load_out0", int'(obs_out0), 0);
        stream(32'b1101101, 7, 1'b1);
        check_val("load_pulses", int'(pulses), 32'b0001001);
        check_val("load_count", int'(cnt0), 2);
        $display("test_pat_load done count=%0d", cnt0);
    endtask

    task automatic test_valid_gaps();
        do_reset();
        stream(32'b10, 2, 1'b1);
        for (int k = 0; k < 3; k++) cycle(bit'(k % 2 == 0), 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        stream(32'b01, 2, 1'b1);
        check_val("gap_pulses", int'(pulses), 32'b01);
        check_val("gap_count", int'(cnt0), 1);
        $display("test_valid_gaps done count=%0d", cnt0);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 21; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        check_val("sat_count", int'(cnt1), 15);
        check_val("sat_flag", int'(sat1), 1);
        check_val("sat_cnt0", int'(cnt0), 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        check_val("clr_out1", int'(obs_out1), 1);
        check_val("clr_count", int'(cnt1), 0);
        check_val("clr_sat", int'(sat1), 0);
        $display("test_saturation done");
    endtask

    task automatic test_async_reset();
        do_reset();
        stream(32'b1001100, 7, 1'b1);
        check_val("ar_pre_count", int'(cnt0), 1);
        #2;
        rst = 1'b0;
        din = 1'b1;
        valid = 1'b1;
        #1;
        check_val("ar_out0", int'(out0), 0);
        check_val("ar_cnt0", int'(cnt0), 0);
        check_val("ar_cnt1", int'(cnt1), 0);
        check_val("ar_sat", int'(sat0 | sat1), 0);
        #1;
        rst = 1'b1;
        valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        stream(32'b1, 1, 1'b1);
        check_val("ar_straddle", int'(pulses), 0);
        stream(32'b1001, 4, 1'b1);
        check_val("ar_post_count", int'(cnt0), 1);
        $display("test_async_reset done count=%0d", cnt0);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cycle(bit'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0,
                  bit'($urandom_range(0, 1)),
                  $urandom_range(0, 31) == 0,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 49) == 0);
        end
        $display("test_random done cnt0=%0d cnt1=%0d", cnt0, cnt1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_pat_load();
        test_valid_gaps();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
